// File: rtl/mem_stage_lsu_if.sv
// Bundles the MEM-stage pipeline inputs, the data-memory handshake and the
// load-result/status outputs of the load/store unit into one port.
interface mem_stage_lsu_if;
   logic        valid_in;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   logic        stall;
   logic [31:0] md;
   logic        md_valid;
   logic        err;
   logic [1:0]  err_code;

   modport master (
      input  valid_in, mem_read, mem_write, funct3, addr, wdata,
      input  dm_ack, dm_rdata,
      output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
      output stall, md, md_valid, err, err_code
   );

   modport slave (
      output valid_in, mem_read, mem_write, funct3, addr, wdata,
      output dm_ack, dm_rdata,
      input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
      input  stall, md, md_valid, err, err_code
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one word-wide handshaked memory access per
// load/store, stalls the pipeline meanwhile and returns the extended load value.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input logic             clk,
   input logic             rstn,
   mem_stage_lsu_if.master bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam bit               TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic        we_q;
   logic        dmReq_q;
   logic        dmWe_q;
   logic [31:0] dmAddr_q;
   logic [3:0]  dmStrb_q;
   logic [31:0] dmWdata_q;
   logic [31:0] md_q;
   logic        mdValid_q;
   logic        err_q;
   logic [1:0]  errCode_q;

   logic        start;
   logic        f3Known;
   logic        illegal;
   logic        misaligned;
   logic        startOk;
   logic        startErr;
   logic [3:0]  storeStrb;
   logic [31:0] storeData;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadValue;
   logic        timeoutHit;

   // Legality is only meaningful for a new access seen while idle.
   always_comb begin
      start   = bus.valid_in & (bus.mem_read | bus.mem_write) & (state_q == IDLE);
      f3Known = 1'b0;
      case (bus.funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3Known = 1'b1;
         default:                                f3Known = 1'b0;
      endcase
      illegal    = (bus.mem_read & bus.mem_write) | ~f3Known | (bus.mem_write & bus.funct3[2]);
      misaligned = ((bus.funct3[1:0] == 2'b01) & bus.addr[0])
                 | ((bus.funct3[1:0] == 2'b10) & (bus.addr[1:0] != 2'b00));
      startOk    = rstn & start & ~illegal & ~misaligned;
      startErr   = rstn & start & (illegal | misaligned);
   end

   always_comb begin
      storeStrb = 4'b0000;
      storeData = bus.wdata;
      if (bus.mem_write) begin
         case (bus.funct3[1:0])
            2'b00: begin
               storeStrb = 4'b0001 << bus.addr[1:0];
               storeData = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
               storeStrb = bus.addr[1] ? 4'b1100 : 4'b0011;
               storeData = {2{bus.wdata[15:0]}};
            end
            default: begin
               storeStrb = 4'b1111;
               storeData = bus.wdata;
            end
         endcase
      end
   end

   // Lane selection uses the offset and size captured at issue time.
   always_comb begin
      loadByte  = bus.dm_rdata[{lo_q, 3'b000} +: 8];
      loadHalf  = bus.dm_rdata[{lo_q[1], 4'b0000} +: 16];
      case (f3_q)
         3'b000:  loadValue = {{24{loadByte[7]}}, loadByte};
         3'b001:  loadValue = {{16{loadHalf[15]}}, loadHalf};
         3'b100:  loadValue = {24'h000000, loadByte};
         3'b101:  loadValue = {16'h0000, loadHalf};
         default: loadValue = bus.dm_rdata;
      endcase
      timeoutHit = TO_EN && (cnt_q == TO_LAST);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         f3_q      <= 3'b000;
         lo_q      <= 2'b00;
         we_q      <= 1'b0;
         dmReq_q   <= 1'b0;
         dmWe_q    <= 1'b0;
         dmAddr_q  <= 32'h0;
         dmStrb_q  <= 4'b0000;
         dmWdata_q <= 32'h0;
         md_q      <= 32'h0;
         mdValid_q <= 1'b0;
         err_q     <= 1'b0;
         errCode_q <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               mdValid_q <= 1'b0;
               err_q     <= 1'b0;
               errCode_q <= 2'b00;
               if (startOk) begin
                  f3_q      <= bus.funct3;
                  lo_q      <= bus.addr[1:0];
                  we_q      <= bus.mem_write;
                  dmReq_q   <= 1'b1;
                  dmWe_q    <= bus.mem_write;
                  dmAddr_q  <= {bus.addr[31:2], 2'b00};
                  dmStrb_q  <= storeStrb;
                  dmWdata_q <= storeData;
                  cnt_q     <= '0;
                  state_q   <= BUSY;
               end
            end
            BUSY: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (bus.dm_ack) begin
                  dmReq_q  <= 1'b0;
                  dmWe_q   <= 1'b0;
                  dmStrb_q <= 4'b0000;
                  if (!we_q) begin
                     md_q      <= loadValue;
                     mdValid_q <= 1'b1;
                  end
                  state_q <= DONE;
               end else if (timeoutHit) begin
                  dmReq_q   <= 1'b0;
                  dmWe_q    <= 1'b0;
                  dmStrb_q  <= 4'b0000;
                  err_q     <= 1'b1;
                  errCode_q <= 2'b11;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               mdValid_q <= 1'b0;
               err_q     <= 1'b0;
               errCode_q <= 2'b00;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Issue-cycle faults report combinationally; timeouts report from DONE.
   always_comb begin
      bus.dm_req   = dmReq_q;
      bus.dm_we    = dmWe_q;
      bus.dm_addr  = dmAddr_q;
      bus.dm_wstrb = dmStrb_q;
      bus.dm_wdata = dmWdata_q;
      bus.md       = md_q;
      bus.md_valid = mdValid_q;
      bus.stall    = rstn & (startOk | (state_q == BUSY));
      bus.err      = err_q | startErr;
      bus.err_code = startErr ? (illegal ? 2'b10 : 2'b01) : errCode_q;
   end

endmodule
